mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the memory word width.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the memory address width (16 words).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 reqN  input  1 (N=0,1)  SHALL be the access request from requester N (0 = sensor sampler, 1 = radio packetizer).
REQ-006 weN  input  1  SHALL select the access type: 1 = write, 0 = read.
REQ-007 addrN  input  ADDR_WIDTH  SHALL be the target address.
REQ-008 wdataN  input  DATA_WIDTH  SHALL be the write data.
REQ-009 gntN  output  1  SHALL be a one-cycle pulse accepting requester N's access.
REQ-010 rvalidN  output  1  SHALL be a one-cycle pulse marking rdataN valid.
REQ-011 rdataN  output  DATA_WIDTH  SHALL carry the read data.
REQ-012 mem_addr, mem_data_in, mem_write, mem_read  output  ADDR_WIDTH/DATA_WIDTH/1/1  SHALL drive the memory port.
REQ-013 mem_data_out  input  DATA_WIDTH  SHALL be the memory read data, valid the cycle after mem_read.
REQ-014 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT; all outputs SHALL be registered.
REQ-016 In IDLE, with any reqN high at the clock edge, the FSM SHALL latch the winner's we/addr/wdata and enter ISSUE.
REQ-017 In ISSUE (one cycle) gntN of the winner, and exactly one of mem_write (we=1) or mem_read (we=0), SHALL be high, with mem_addr/mem_data_in driven from the latched values.
REQ-018 After ISSUE, a write SHALL return to IDLE; a read SHALL enter WAIT.
REQ-019 In WAIT the arbiter SHALL capture mem_data_out into rdataN and assert rvalidN in the following cycle while returning to IDLE.
REQ-020 Latencies: write request sampled at edge E -> gnt/mem_write in cycle E+1; read -> gnt/mem_read E+1, rvalid E+3.
REQ-021 Requesters SHALL hold req and fields stable until gnt; req still high in the cycle after gnt SHALL be treated as a new request.
REQ-022 Round-robin: on simultaneous requests, the port not granted most recently SHALL win; a single requester SHALL always win.
REQ-023 At most one memory strobe SHALL be high in any cycle; mem_write and mem_read SHALL never be high together.
REQ-024 rdataN SHALL hold its last value between rvalid pulses; rdata of the non-granted port SHALL not change.
REQ-025 Back-to-back: a pending request SHALL be sampled in the first IDLE cycle after completion (no extra idle cycle).

Reset
REQ-026 On rst: state IDLE, all gnt/rvalid/mem_write/mem_read/busy 0, rdata/mem_addr/mem_data_in 0, round-robin pointer selecting port 0 first.
REQ-027 rst asserted in ISSUE or WAIT SHALL abort the access; no rvalid SHALL be issued for it.

Configuration
REQ-028 Macro MEM_ARB_FIXED_PRIO_EN defined: port 0 SHALL always win simultaneous requests; undefined: round-robin per REQ-022.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the FSM state encoding, port index constants and default widths.
REQ-030 Winner selection SHALL be a sub-module rr_arbiter_2 (2-way round-robin with pointer and fixed-priority option).

Verification
REQ-031 Reset, then port0 write addr 3 data 0x06 -> gnt0 and mem_write cycle after sampling, mem_addr=3, mem_data_in=0x06.
REQ-032 Port1 read addr 3 after REQ-031 -> mem_read at E+1, rvalid1 at E+3, rdata1=0x06.
REQ-033 Both ports request simultaneously three times -> grants 0,1,0 (round-robin); with MEM_ARB_FIXED_PRIO_EN -> 0,0,0 while port0 keeps requesting.
REQ-034 Write all 16 addresses data=2*addr via port0, read all via port1 -> rdata1 = 2*addr each, never mem_write and mem_read together.
REQ-035 rst asserted during WAIT of a read -> no rvalid, all outputs 0 next cycle, next simultaneous request granted to port 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding, port indices,
// default widths and a small port helper.
package mem_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int NUM_PORTS      = 2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_ISSUE = 2'b01;
  localparam state_t ST_WAIT  = 2'b10;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the memory port of mem_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_write;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_data_in, mem_write, mem_read, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_data_in, mem_write, mem_read, busy
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin winner selection; the pointer names the port with
// priority and moves to the other port after each accepted grant.
module rr_arbiter_2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic prio_r;

  // Winner select: only a simultaneous request consults the pointer
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      if (FIXED_PRIO || (prio_r == PORT0)) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end else begin
      grant = req;
    end
  end

  // Priority pointer: hand priority to the port that just lost
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= PORT0;
    end else if (update && (grant != 2'b00)) begin
      prio_r <= other_port(grant[1]);
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter (IDLE/ISSUE/WAIT), registered outputs.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every simultaneous request.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO_C = 1'b1;
`else
  localparam bit FIXED_PRIO_C = 1'b0;
`endif

  state_t                state_r;
  state_t                next_state_s;
  logic                  any_req_s;
  logic                  update_s;
  logic [1:0]            grant_s;
  logic                  win_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;

  logic                  port_r;
  logic                  we_r;
  logic                  gnt0_r;
  logic                  gnt1_r;
  logic                  rvalid0_r;
  logic                  rvalid1_r;
  logic [DATA_WIDTH-1:0] rdata0_r;
  logic [DATA_WIDTH-1:0] rdata1_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_data_in_r;
  logic                  mem_write_r;
  logic                  mem_read_r;
  logic                  busy_r;

  assign any_req_s = bus.req0 | bus.req1;
  assign update_s  = (state_r == ST_IDLE) && any_req_s;

  rr_arbiter_2 #(
    .FIXED_PRIO (FIXED_PRIO_C)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.req1, bus.req0}),
    .update (update_s),
    .grant  (grant_s)
  );

  // Winner index and its request fields
  always_comb begin
    win_s       = PORT0;
    sel_we_s    = bus.we0;
    sel_addr_s  = bus.addr0;
    sel_wdata_s = bus.wdata0;
    if (grant_s[1]) begin
      win_s       = PORT1;
      sel_we_s    = bus.we1;
      sel_addr_s  = bus.addr1;
      sel_wdata_s = bus.wdata1;
    end else begin
      win_s       = PORT0;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (we_r) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_WAIT: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      busy_r        <= 1'b0;
      port_r        <= PORT0;
      we_r          <= 1'b0;
      gnt0_r        <= 1'b0;
      gnt1_r        <= 1'b0;
      rvalid0_r     <= 1'b0;
      rvalid1_r     <= 1'b0;
      rdata0_r      <= {DATA_WIDTH{1'b0}};
      rdata1_r      <= {DATA_WIDTH{1'b0}};
      mem_addr_r    <= {ADDR_WIDTH{1'b0}};
      mem_data_in_r <= {DATA_WIDTH{1'b0}};
      mem_write_r   <= 1'b0;
      mem_read_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          rvalid0_r <= 1'b0;
          rvalid1_r <= 1'b0;
          if (any_req_s) begin
            port_r        <= win_s;
            we_r          <= sel_we_s;
            mem_addr_r    <= sel_addr_s;
            mem_data_in_r <= sel_wdata_s;
            gnt0_r        <= (win_s == PORT0);
            gnt1_r        <= (win_s == PORT1);
            mem_write_r   <= sel_we_s;
            mem_read_r    <= ~sel_we_s;
          end
        end
        ST_ISSUE: begin
          gnt0_r      <= 1'b0;
          gnt1_r      <= 1'b0;
          mem_write_r <= 1'b0;
          mem_read_r  <= 1'b0;
        end
        ST_WAIT: begin
          // Memory data is valid now, one cycle after the read strobe
          if (port_r == PORT1) begin
            rdata1_r  <= bus.mem_data_out;
            rvalid1_r <= 1'b1;
          end else begin
            rdata0_r  <= bus.mem_data_out;
            rvalid0_r <= 1'b1;
          end
        end
        default: begin
          gnt0_r      <= 1'b0;
          gnt1_r      <= 1'b0;
          rvalid0_r   <= 1'b0;
          rvalid1_r   <= 1'b0;
          mem_write_r <= 1'b0;
          mem_read_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0        = gnt0_r;
  assign bus.gnt1        = gnt1_r;
  assign bus.rvalid0     = rvalid0_r;
  assign bus.rvalid1     = rvalid1_r;
  assign bus.rdata0      = rdata0_r;
  assign bus.rdata1      = rdata1_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_data_in = mem_data_in_r;
  assign bus.mem_write   = mem_write_r;
  assign bus.mem_read    = mem_read_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 16-word memory model behind the port.
module tb_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   collisions = 0;
  logic [DW-1:0] mem_model [16];

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory: write on strobe, read data valid the cycle after mem_read
  always @(posedge clk) begin
    if (bus.mem_write) mem_model[bus.mem_addr] <= bus.mem_data_in;
    if (bus.mem_read)  bus.mem_data_out <= mem_model[bus.mem_addr];
  end

  always @(negedge clk) begin
    if (bus.mem_write && bus.mem_read) collisions++;
  end

  task automatic raise(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic test_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 4'h0; bus.addr1 = 4'h0; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_write, bus.mem_read, bus.busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_write, bus.mem_read, bus.busy});
    end
    checks++;
    if ({bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_data_in} !== 28'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_data_in});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    raise(0, 1'b1, 4'd3, 8'h06);
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.mem_write, bus.mem_read, bus.busy, bus.mem_addr, bus.mem_data_in} !== {5'b10101, 4'd3, 8'h06}) begin
      errors++;
      $display("FAIL write_issue: got %b %h %h want 10101 3 06", {bus.gnt0, bus.gnt1, bus.mem_write, bus.mem_read, bus.busy}, bus.mem_addr, bus.mem_data_in);
    end
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.mem_write, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL write_done: got %b want 000", {bus.gnt0, bus.mem_write, bus.busy});
    end
  endtask

  task automatic test_read();
    raise(1, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    checks++;
    if ({bus.gnt1, bus.gnt0, bus.mem_read, bus.mem_write, bus.rvalid1, bus.mem_addr} !== {5'b10100, 4'd3}) begin
      errors++;
      $display("FAIL read_issue: got %b %h want 10100 3", {bus.gnt1, bus.gnt0, bus.mem_read, bus.mem_write, bus.rvalid1}, bus.mem_addr);
    end
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.gnt1, bus.mem_read, bus.rvalid1, bus.busy} !== 4'b0001) begin
      errors++;
      $display("FAIL read_wait: got %b want 0001", {bus.gnt1, bus.mem_read, bus.rvalid1, bus.busy});
    end
    @(negedge clk);
    checks++;
    if ({bus.rvalid1, bus.rvalid0, bus.busy, bus.rdata1, bus.rdata0} !== {3'b100, 8'h06, 8'h00}) begin
      errors++;
      $display("FAIL read_rvalid: got %b %h %h want 100 06 00", {bus.rvalid1, bus.rvalid0, bus.busy}, bus.rdata1, bus.rdata0);
    end
    @(negedge clk);
    checks++;
    if ({bus.rvalid1, bus.rdata1} !== {1'b0, 8'h06}) begin
      errors++;
      $display("FAIL read_hold: got %b %h want 0 06", bus.rvalid1, bus.rdata1);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    for (int i = 0; i < 3; i++) begin
      raise(0, 1'b1, 4'd10, 8'hA0);
      raise(1, 1'b1, 4'd11, 8'hB1);
      exp_g = (FIXED || (i != 1)) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++;
      if ({bus.gnt1, bus.gnt0} !== exp_g) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", i, {bus.gnt1, bus.gnt0}, exp_g);
      end
      checks++;
      if (bus.mem_addr !== (exp_g[1] ? 4'd11 : 4'd10)) begin
        errors++;
        $display("FAIL rr_addr%0d: got %h want %h", i, bus.mem_addr, exp_g[1] ? 4'd11 : 4'd10);
      end
      if (exp_g[1]) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      @(negedge clk);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 16; a++) begin
      raise(0, 1'b1, a[AW-1:0], 8'(2 * a));
      @(negedge clk);
      checks++;
      if ({bus.gnt0, bus.mem_write, bus.mem_addr, bus.mem_data_in} !== {2'b11, a[AW-1:0], 8'(2 * a)}) begin
        errors++;
        $display("FAIL fill_wr%0d: got %b %h %h", a, {bus.gnt0, bus.mem_write}, bus.mem_addr, bus.mem_data_in);
      end
      bus.req0 = 1'b0;
      @(negedge clk);
    end
    for (int a = 0; a < 16; a++) begin
      raise(1, 1'b0, a[AW-1:0], 8'h00);
      @(negedge clk);
      bus.req1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus.rvalid1, bus.rdata1} !== {1'b1, 8'(2 * a)}) begin
        errors++;
        $display("FAIL fill_rd%0d: got %b %h want 1 %h", a, bus.rvalid1, bus.rdata1, 8'(2 * a));
      end
    end
    checks++;
    if (collisions !== 0) begin
      errors++;
      $display("FAIL strobe_overlap: got %0d want 0", collisions);
    end
  endtask

  task automatic test_reset_abort();
    raise(0, 1'b0, 4'd5, 8'h00);
    @(negedge clk);
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_write, bus.mem_read, bus.busy} !== 7'b0) begin
      errors++;
      $display("FAIL abort_ctrl: got %b want 0000000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_write, bus.mem_read, bus.busy});
    end
    checks++;
    if ({bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_data_in} !== 28'h0) begin
      errors++;
      $display("FAIL abort_data: got %h want 0", {bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_data_in});
    end
    rst = 1'b0;
    raise(0, 1'b1, 4'd1, 8'h11);
    raise(1, 1'b1, 4'd2, 8'h22);
    @(negedge clk);
    checks++;
    if ({bus.gnt1, bus.gnt0, bus.rvalid0} !== 3'b010) begin
      errors++;
      $display("FAIL abort_next_grant: got %b want 010", {bus.gnt1, bus.gnt0, bus.rvalid0});
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
